// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 packet router: header latch, FIFO byte
// forwarding with one-byte overflow buffer, and running XOR parity check.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
    logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
    logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
    logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  parity_done_q, parity_done_d;
    logic                  low_pkt_valid_q, low_pkt_valid_d;
    logic                  err_q, err_d;
    logic                  parity_capture;

    always_comb begin
        hdr_d           = hdr_q;
        full_byte_d     = full_byte_q;
        int_par_d       = int_par_q;
        pkt_par_d       = pkt_par_q;
        dout_d          = dout_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        err_d           = err_q;

        // Parity byte reaches the FIFO either directly or after a full stall.
        parity_capture = (ld_state && !fifo_full && !pkt_valid) ||
                         (laf_state && low_pkt_valid_q && !parity_done_q);

        if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
            hdr_d = data_in;
        end

        if (lfd_state) begin
            dout_d = hdr_q;
        end else if (ld_state && !fifo_full) begin
            dout_d = data_in;
        end else if (ld_state && fifo_full) begin
            full_byte_d = data_in;
        end else if (laf_state) begin
            dout_d = full_byte_q;
        end

        if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end

        if (detect_add) begin
            parity_done_d = 1'b0;
            pkt_par_d     = '0;
        end else if (parity_capture) begin
            parity_done_d = 1'b1;
            pkt_par_d     = data_in;
        end

        // Payload bytes stalled into full_byte are still folded in here.
        if (detect_add) begin
            int_par_d = '0;
        end else if (lfd_state) begin
            int_par_d = int_par_q ^ hdr_q;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_par_d = int_par_q ^ data_in;
        end

        if (detect_add) begin
            err_d = 1'b0;
        end else if (parity_done_q) begin
            err_d = (int_par_q != pkt_par_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hdr_q           <= '0;
            full_byte_q     <= '0;
            int_par_q       <= '0;
            pkt_par_q       <= '0;
            dout_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            hdr_q           <= hdr_d;
            full_byte_q     <= full_byte_d;
            int_par_q       <= int_par_d;
            pkt_par_q       <= pkt_par_d;
            dout_q          <= dout_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;

endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage of the 1x3 packet router, directly downstream of the router FSM. Driven by the FSM state flags, it latches the header, forwards header/payload/parity bytes to the selected output FIFO, and buffers the one byte that arrives when the FIFO fills. It computes a running XOR parity and reports `parity_done`, `low_pkt_valid` and `err` back to the FSM and to the host.

## Interface
- `DATA_WIDTH`, 8, byte width; bits [1:0] of a header are the destination address, bits [DATA_WIDTH-1:2] are the payload length.
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `pkt_valid` input 1: source asserts for header and payload bytes, drops on the parity byte.
- `data_in` input DATA_WIDTH: source byte stream.
- `fifo_full` input 1: selected output FIFO is full.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` input 1 each: FSM state flags, one-hot or all low.
- `dout` output DATA_WIDTH: byte written to the FIFO. The FIFO write strobe is the FSM's `write_enb_reg`.
- `parity_done` output 1: the parity byte has been forwarded.
- `low_pkt_valid` output 1: `pkt_valid` fell while loading data.
- `err` output 1: the received parity byte does not match the computed parity.

## Operation
- Registers: `hdr`, `full_byte`, `int_par`, `pkt_par` (each DATA_WIDTH), plus the outputs. Reset (`resetn`=0 at an edge) clears all of them to 0. Reset has priority over every other condition.
- `hdr`: loads `data_in` when `detect_add & pkt_valid & data_in[1:0]!=2'b11`. Otherwise it holds.
- `dout` priority:
  1. `lfd_state`: load `hdr`.
  2. `ld_state & !fifo_full`: load `data_in`.
  3. `ld_state & fifo_full`: `full_byte` loads `data_in` and `dout` holds.
  4. `laf_state`: load `full_byte`.
  5. Otherwise: hold.
- `low_pkt_valid`: cleared by `rst_int_reg`. Otherwise set by `ld_state & !pkt_valid`. Otherwise it holds.
- `parity_done`:
  - Cleared by `detect_add`.
  - Otherwise set by either `ld_state & !fifo_full & !pkt_valid` or `laf_state & low_pkt_valid & !parity_done`.
  - Otherwise it holds.
- `pkt_par`: cleared by `detect_add`. Otherwise it loads `data_in` under the same two set conditions as `parity_done`.
- `int_par`:
  - Cleared by `detect_add`.
  - Otherwise `int_par ^ hdr` on `lfd_state`.
  - Otherwise `int_par ^ data_in` on `ld_state & pkt_valid & !full_state`. This includes the byte captured into `full_byte`.
  - Otherwise it holds.
- `err`:
  - Cleared by `detect_add`.
  - Otherwise, while `parity_done`=1, it loads `(int_par != pkt_par)`.
  - Otherwise it holds.
- The XOR covers exactly: header, every payload byte, and no parity byte.

## Timing
- All outputs are registered, so each has 1-cycle latency from its qualifying input edge.
- `dout` equals the header one cycle after the `lfd_state` cycle.
- `dout` equals payload byte k one cycle after the cycle in which that byte was presented with `ld_state` high and `fifo_full` low.
- Parity byte presented at edge N (`ld_state=1`, `pkt_valid=0`, `fifo_full=0`):
  - `dout`, `pkt_par` and `parity_done` update at N.
  - `err` is valid at N+1.
- FIFO full during load: the byte at edge N is held in `full_byte`. It appears on `dout` one cycle after the first `laf_state` edge. No byte is lost or duplicated.
- Full exactly on the parity byte: `low_pkt_valid` sets at N. On the first `laf_state` edge, `parity_done` sets and `pkt_par` captures `data_in`. The source must hold the parity byte on `data_in` through that edge.
- `detect_add` and `rst_int_reg` both asserted: each clears its own register and there is no conflict. This case is unreachable from the FSM.
- Reset mid-packet: the next edge with `resetn`=0 zeroes everything. The following packet starts from clean parity.
- Soft reset through the FSM re-enters `detect_add`, which clears `int_par`, `pkt_par`, `parity_done` and `err`.

## Test plan
- Reset: drive garbage on every input with `resetn`=0 for 2 cycles. Required: `dout`=0x00, `parity_done`=0, `low_pkt_valid`=0, `err`=0.
- Good packet, address 1: header 0x0D (length 3), payloads 0x11/0x22/0x33, parity 0x0D. Required: `dout` sequence 0x0D,0x11,0x22,0x33,0x0D, `parity_done`=1, `err`=0 one cycle later.
- Bad parity: same packet with parity byte 0x0E. Required: `err`=1 one cycle after `parity_done`, and `err` clears on the next `detect_add`.
- FIFO full mid-payload: assert `fifo_full` while 0x22 is presented, hold for 3 cycles, then run `full_state` followed by `laf_state`. Required: `dout` holds 0x11, then shows 0x22 after `laf_state`, then continues with 0x33, and `err`=0.
- Full on the parity byte: `fifo_full` during the parity cycle. Required: `low_pkt_valid`=1, then `parity_done`=1 after the `laf_state` edge, `pkt_par`=0x0D, `err`=0, and `low_pkt_valid` cleared by `rst_int_reg`.
- Invalid address: header 0x0F with `detect_add`. Required: `hdr` unchanged from its previous value, and `dout` unchanged.
